// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: memory mode codes, FSM state codes and sizing helpers.
package mem_arbiter_pkg;

  localparam logic [1:0] MEM_MODE_IDLE = 2'b00;
  localparam logic [1:0] MEM_MODE_IN   = 2'b01;  // write
  localparam logic [1:0] MEM_MODE_OUT  = 2'b10;  // read

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_ACCESS = 2'b01,
    ARB_RESP   = 2'b10
  } arb_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Rotating priority encoder: first set request bit searching upward from ptr+1, wrapping at NREQ.
module mem_arbiter_rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   winner_c_o,
  output logic            any_c_o
);

  logic [IW-1:0] idx;

  // Walk from the farthest offset down so the nearest set bit after ptr wins.
  always_comb begin
    winner_c_o = '0;
    idx        = '0;
    any_c_o    = |req_i;
    for (int i = int'(NREQ); i >= 1; i--) begin
      idx = IW'((int'(ptr_i) + i) % int'(NREQ));
      if (req_i[idx]) winner_c_o = idx;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported word memory among NREQ requesters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 16,
  parameter int unsigned DW   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ-1:0]  we_i,
  input  logic [AW*NREQ-1:0] addr_i,
  input  logic [DW*NREQ-1:0] wdata_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [NREQ-1:0]  rvalid_o,
  output logic [DW-1:0]    rdata_o,
  output logic             busy_o,
  output logic [1:0]       mem_mode_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  input  logic [DW-1:0]    mem_rdata_i
);

  localparam int unsigned IW = idx_w(NREQ);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic            wr_q, wr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic [1:0]      mem_mode_q, mem_mode_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic [IW-1:0]   win_c;
  logic            any_c;
  logic [AW-1:0]   addr_a  [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_slice
    assign addr_a[g]  = addr_i[AW*g +: AW];
    assign wdata_a[g] = wdata_i[DW*g +: DW];
  end

  mem_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i      (req_i),
    .ptr_i      (ptr_q),
    .winner_c_o (win_c),
    .any_c_o    (any_c)
  );

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    wr_d        = wr_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    mem_mode_d  = MEM_MODE_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_c) begin
          mem_mode_d   = we_i[win_c] ? MEM_MODE_IN : MEM_MODE_OUT;
          mem_addr_d   = addr_a[win_c];
          mem_wdata_d  = wdata_a[win_c];
          gnt_d[win_c] = 1'b1;
          ptr_d        = win_c;
          win_d        = win_c;
          wr_d         = we_i[win_c];
          state_d      = ARB_ACCESS;
        end
      end
      ARB_ACCESS: state_d = wr_q ? ARB_IDLE : ARB_RESP;
      ARB_RESP: begin
        rdata_d         = mem_rdata_i;
        rvalid_d[win_q] = 1'b1;
        state_d         = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // Pointer resets to the last requester so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= IW'(NREQ - 1);
      win_q       <= '0;
      wr_q        <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_mode_q  <= MEM_MODE_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      wr_q        <= wr_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_mode_q  <= mem_mode_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = busy_q;
  assign mem_mode_o  = mem_mode_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: mem_arbiter driving a small synchronous word memory model.
module tb_mem_arbiter;

  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_IN   = 2'b01;
  localparam logic [1:0] M_OUT  = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we, gnt, rvalid, mem_mode;
  logic [31:0] addr, wdata;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  logic [15:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NREQ(2), .AW(16), .DW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .mem_mode_o  (mem_mode),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Memory acts on the edge that sees its mode; read data is valid the following cycle.
  always @(posedge clk) begin
    if (mem_mode == M_IN)  mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_mode == M_OUT) mem_rdata <= mem[mem_addr[7:0]];
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) assert (!$isunknown(req)) else $error("FAIL req_known: observed %b expected no X", req);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [1:0] exp_g;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101);
    mem[8'h10] = 16'hBEEF;
    mem_rdata = '0;
    req = '0; we = '0; addr = '0; wdata = '0;
    do_reset();
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_mode", 32'(mem_mode), 32'(M_IDLE));
    check("reset_rdata", 32'(rdata), 32'h0);

    // Single read by requester 0
    req = 2'b01; we = 2'b00; addr = {16'h0000, 16'h0010};
    tick();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_mode", 32'(mem_mode), 32'(M_OUT));
    check("t1_addr", 32'(mem_addr), 32'h0010);
    check("t1_busy_k1", 32'(busy), 32'h1);
    req = 2'b00;
    tick();
    check("t1_gnt_drop", 32'(gnt), 32'h0);
    check("t1_mode_idle", 32'(mem_mode), 32'(M_IDLE));
    check("t1_no_rvalid_k2", 32'(rvalid), 32'h0);
    tick();
    check("t1_rvalid", 32'(rvalid), 32'h1);
    check("t1_rdata", 32'(rdata), 32'hBEEF);
    check("t1_busy_k3", 32'(busy), 32'h0);
    tick();
    check("t1_rvalid_pulse", 32'(rvalid), 32'h0);

    // Write then read by requester 1
    req = 2'b10; we = 2'b10; addr = {16'h0020, 16'h0000}; wdata = {16'h1234, 16'h0000};
    tick();
    check("t2_gnt", 32'(gnt), 32'h2);
    check("t2_mode", 32'(mem_mode), 32'(M_IN));
    check("t2_addr", 32'(mem_addr), 32'h0020);
    check("t2_wdata", 32'(mem_wdata), 32'h1234);
    req = 2'b00;
    tick();
    check("t2_mem_written", 32'(mem[8'h20]), 32'h1234);
    check("t2_busy_after_wr", 32'(busy), 32'h0);
    check("t2_rdata_kept", 32'(rdata), 32'hBEEF);
    check("t2_no_rvalid_wr", 32'(rvalid), 32'h0);
    req = 2'b10; we = 2'b00;
    tick();
    check("t2_rd_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    tick();
    tick();
    check("t2_rvalid", 32'(rvalid), 32'h2);
    check("t2_rdata", 32'(rdata), 32'h1234);

    // Contention from reset: grants alternate 0,1,...
    do_reset();
    req = 2'b11; we = 2'b00; addr = {16'h0020, 16'h0010};
    for (int g = 0; g < 8; g++) begin
      n = 0;
      tick();
      while (gnt == 2'b00 && n < 10) begin
        tick();
        n++;
      end
      check("t3_wait_bound", 32'(n < 10), 32'h1);
      exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("t3_gnt_%0d", g), 32'(gnt), 32'(exp_g));
    end
    req = 2'b00;
    tick(); tick(); tick();

    // Simultaneous read (req0) and write (req1) to the same word
    do_reset();
    req = 2'b11; we = 2'b10; addr = {16'h0003, 16'h0003}; wdata = {16'hAAAA, 16'h0000};
    tick();
    check("t4_gnt0", 32'(gnt), 32'h1);
    check("t4_mode_rd", 32'(mem_mode), 32'(M_OUT));
    req = 2'b10;
    tick();
    tick();
    check("t4_rvalid0", 32'(rvalid), 32'h1);
    check("t4_old_value", 32'(rdata), 32'h0303);
    tick();
    check("t4_gnt1", 32'(gnt), 32'h2);
    check("t4_mode_wr", 32'(mem_mode), 32'(M_IN));
    req = 2'b00;
    tick();
    check("t4_mem_new", 32'(mem[8'h03]), 32'hAAAA);
    req = 2'b01; we = 2'b00;
    tick();
    check("t4_regnt0", 32'(gnt), 32'h1);
    req = 2'b00;
    tick();
    tick();
    check("t4_rerd_valid", 32'(rvalid), 32'h1);
    check("t4_rerd_data", 32'(rdata), 32'hAAAA);

    // Reset asserted while a read is in ACCESS
    req = 2'b10; we = 2'b00; addr = {16'h0010, 16'h0010};
    tick();
    check("t5_gnt1", 32'(gnt), 32'h2);
    req = 2'b00;
    rst_n = 1'b0;
    #1;
    check("t5_mode_idle_now", 32'(mem_mode), 32'(M_IDLE));
    check("t5_busy_clear", 32'(busy), 32'h0);
    check("t5_rdata_clear", 32'(rdata), 32'h0);
    tick();
    check("t5_no_rvalid_rst", 32'(rvalid), 32'h0);
    rst_n = 1'b1;
    tick();
    check("t5_no_rvalid_a", 32'(rvalid), 32'h0);
    tick();
    check("t5_no_rvalid_b", 32'(rvalid), 32'h0);
    req = 2'b11;
    tick();
    check("t5_first_win0", 32'(gnt), 32'h1);
    req = 2'b00;
    tick(); tick(); tick();

    // Idle: nothing moves without requests
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("t6_idle_%0d", c), {26'h0, mem_mode, gnt, rvalid, busy}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
